// File: rtl/uart_frame_sender.sv
// uart_frame_sender: frames (A,B) pairs as HEADER,A,B and feeds a byte-wide UART.
// Define FRAME_CHECKSUM_EN to append a fourth byte, HEADER ^ A ^ B.
module uart_frame_sender #(
    parameter logic [7:0] HEADER       = 8'h0A,
    parameter int         EN_CYCLES    = 3,
    parameter int         BUSY_TIMEOUT = 16
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic       req_ready,
    input  logic       tx_status,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic       busy,
    output logic       frame_done,
    output logic       timeout_err
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD      = 3'd1;
    localparam logic [2:0] PULSE     = 3'd2;
    localparam logic [2:0] WAIT_BUSY = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;
    localparam logic [2:0] NEXT      = 3'd5;

`ifdef FRAME_CHECKSUM_EN
    localparam logic [1:0] LAST_IDX = 2'd3;
`else
    localparam logic [1:0] LAST_IDX = 2'd2;
`endif

    localparam logic [3:0] EN_LOAD = 4'(EN_CYCLES - 1);
    localparam logic [7:0] TO_LOAD = 8'(BUSY_TIMEOUT - 1);

    logic [2:0] state;
    logic [1:0] idx;
    logic [3:0] en_cnt;
    logic [7:0] to_cnt;

    logic       rsv_full;
    logic [7:0] rsv_a;
    logic [7:0] rsv_b;
    logic [7:0] act_a;
    logic [7:0] act_b;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0] act_ck;
`endif

    logic       accept;
    logic       handover;
    logic [7:0] cur_byte;

    assign req_ready  = ~rsv_full;
    assign accept     = req_valid & ~rsv_full;
    assign handover   = (state == IDLE) & rsv_full;

    assign tx_en      = (state == PULSE);
    assign busy       = (state != IDLE);
    assign frame_done = (state == NEXT) && (idx == LAST_IDX);

    // Reserve slot: filled on accept, emptied when the FSM takes it over.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            rsv_full <= 1'b0;
            rsv_a    <= 8'h00;
            rsv_b    <= 8'h00;
        end else if (accept) begin
            rsv_a    <= req_a;
            rsv_b    <= req_b;
            rsv_full <= 1'b1;
        end else if (handover) begin
            rsv_full <= 1'b0;
        end
    end

    // Active frame registers, loaded from the reserve at handover.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            act_a  <= 8'h00;
            act_b  <= 8'h00;
`ifdef FRAME_CHECKSUM_EN
            act_ck <= 8'h00;
`endif
        end else if (handover) begin
            act_a  <= rsv_a;
            act_b  <= rsv_b;
`ifdef FRAME_CHECKSUM_EN
            act_ck <= HEADER ^ rsv_a ^ rsv_b;
`endif
        end
    end

    // Select the byte for the current index.
    always_comb begin
        cur_byte = HEADER;
        case (idx)
            2'd1:    cur_byte = act_a;
            2'd2:    cur_byte = act_b;
`ifdef FRAME_CHECKSUM_EN
            2'd3:    cur_byte = act_ck;
`endif
            default: cur_byte = HEADER;
        endcase
    end

    // Byte sequencer: load, strobe, wait for the UART to take and finish the byte.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= 2'd0;
            en_cnt      <= 4'd0;
            to_cnt      <= 8'd0;
            tx_data     <= 8'h00;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handover) begin
                        idx   <= 2'd0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    tx_data <= cur_byte;
                    en_cnt  <= EN_LOAD;
                    if (tx_status) begin
                        state <= PULSE;
                    end
                end
                PULSE: begin
                    if (en_cnt == 4'd0) begin
                        to_cnt <= TO_LOAD;
                        state  <= WAIT_BUSY;
                    end else begin
                        en_cnt <= en_cnt - 4'd1;
                    end
                end
                WAIT_BUSY: begin
                    if (!tx_status) begin
                        state <= WAIT_IDLE;
                    end else if (to_cnt == 8'd0) begin
                        timeout_err <= 1'b1;
                        state       <= NEXT;
                    end else begin
                        to_cnt <= to_cnt - 8'd1;
                    end
                end
                WAIT_IDLE: begin
                    if (tx_status) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (idx == LAST_IDX) begin
                        state <= IDLE;
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_sender.sv
// tb_uart_frame_sender: scoreboard bench for uart_frame_sender with a UART model.
// Expected bytes are queued at accept time and popped on each tx_en rise.
module tb_uart_frame_sender;

    localparam logic [7:0] HDR = 8'h0A;
`ifdef FRAME_CHECKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    logic       sysclk    = 1'b0;
    logic       reset     = 1'b1;
    logic       req_valid = 1'b0;
    logic [7:0] req_a     = 8'h00;
    logic [7:0] req_b     = 8'h00;
    logic       req_ready;
    logic       tx_status = 1'b1;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       busy;
    logic       frame_done;
    logic       timeout_err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] exp_q[$];

    // UART model mode: 0 = normal, 1 = held busy, 2 = never drops
    int   uart_mode = 0;
    int   low_cnt   = 0;
    int   fall_dly  = 0;
    logic en_prev_u = 1'b0;

    int   en_len    = 0;
    int   nbytes    = 0;
    int   fd_cnt    = 0;
    logic en_prev_m = 1'b0;
    logic [7:0] e;

    uart_frame_sender dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .tx_status   (tx_status),
        .tx_data     (tx_data),
        .tx_en       (tx_en),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    always #5 sysclk = ~sysclk;

    // UART model: status falls 2 cycles after tx_en rises, low for 20 cycles
    initial forever begin
        @(negedge sysclk);
        if (reset) begin
            fall_dly  = 0;
            low_cnt   = 0;
            en_prev_u = 1'b0;
            tx_status = (uart_mode != 1);
        end else begin
            if (uart_mode == 1) begin
                tx_status = 1'b0;
            end else if (uart_mode == 2) begin
                tx_status = 1'b1;
            end else if (low_cnt > 0) begin
                low_cnt--;
                tx_status = (low_cnt == 0);
            end else if (fall_dly > 0) begin
                fall_dly--;
                if (fall_dly == 0) begin
                    tx_status = 1'b0;
                    low_cnt   = 20;
                end
            end else begin
                tx_status = 1'b1;
                if (tx_en && !en_prev_u) fall_dly = 1;
            end
            en_prev_u = tx_en;
        end
    end

    // Monitor: byte scoreboard, strobe length, bytes per frame
    initial forever begin
        @(negedge sysclk);
        if (reset) begin
            en_len    = 0;
            nbytes    = 0;
            en_prev_m = 1'b0;
        end else begin
            if (tx_en) en_len++;
            if (tx_en && !en_prev_m) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL byte: got %02h, none expected", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e)
                        $display("FAIL byte: got %02h expected %02h", tx_data, e);
                    else
                        n_pass++;
                end
                nbytes++;
            end
            if (!tx_en && en_prev_m) begin
                n_chk++;
                if (en_len !== 3)
                    $display("FAIL en_len: got %0d expected 3", en_len);
                else
                    n_pass++;
                en_len = 0;
            end
            if (frame_done) begin
                fd_cnt++;
                n_chk++;
                if (nbytes !== NB)
                    $display("FAIL frame_len: got %0d expected %0d", nbytes, NB);
                else
                    n_pass++;
                nbytes = 0;
            end
            en_prev_m = tx_en;
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit keep);
        bit ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        for (int t = 0; t < 400; t++) begin
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge sysclk);
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL accept: got ready=0 expected ready=1");
            req_valid = 1'b0;
            return;
        end
        exp_q.push_back(HDR);
        exp_q.push_back(a);
        exp_q.push_back(b);
`ifdef FRAME_CHECKSUM_EN
        exp_q.push_back(HDR ^ a ^ b);
`endif
        @(posedge sysclk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_en(input logic v);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            if (tx_en === v) begin
                ok = 1'b1;
                break;
            end
            @(negedge sysclk);
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL wait_en: got %b expected %b", tx_en, v);
        end
    endtask

    task automatic wait_fd();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge sysclk);
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL wait_fd: got frame_done=0 expected 1");
        end
    endtask

    task automatic wait_idle();
        int run;
        run = 0;
        for (int t = 0; t < 4000 && run < 3; t++) begin
            @(negedge sysclk);
            if (busy === 1'b0 && req_ready === 1'b1 &&
                tx_status === 1'b1 && exp_q.size() == 0)
                run++;
            else
                run = 0;
        end
        n_chk++;
        if (run < 3)
            $display("FAIL idle: got busy=%b left=%0d expected idle, 0", busy, exp_q.size());
        else
            n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge sysclk);
        n_chk++; if (tx_data !== 8'h00) $display("FAIL rst_data: got %02h expected 00", tx_data); else n_pass++;
        n_chk++; if (tx_en !== 1'b0) $display("FAIL rst_en: got %b expected 0", tx_en); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
        n_chk++; if (frame_done !== 1'b0) $display("FAIL rst_fd: got %b expected 0", frame_done); else n_pass++;
        n_chk++; if (timeout_err !== 1'b0) $display("FAIL rst_to: got %b expected 0", timeout_err); else n_pass++;
        n_chk++; if (req_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", req_ready); else n_pass++;
        reset = 1'b0;
        @(negedge sysclk);
    endtask

    task automatic test_single();
        int fd0;
        fd0 = fd_cnt;
        send(8'h12, 8'h34, 1'b0);
        @(negedge sysclk);
        @(negedge sysclk);
        n_chk++; if (tx_en !== 1'b0) $display("FAIL lat_c2: got %b expected 0", tx_en); else n_pass++;
        @(negedge sysclk);
        n_chk++; if (tx_en !== 1'b1) $display("FAIL lat_c3: got %b expected 1", tx_en); else n_pass++;
        wait_fd();
        @(negedge sysclk);
        n_chk++; if (busy !== 1'b0) $display("FAIL busy_fall: got %b expected 0", busy); else n_pass++;
        n_chk++; if (frame_done !== 1'b0) $display("FAIL fd_pulse: got %b expected 0", frame_done); else n_pass++;
        wait_idle();
        n_chk++; if (fd_cnt - fd0 !== 1) $display("FAIL fd_single: got %0d expected 1", fd_cnt - fd0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int fd0;
        fd0 = fd_cnt;
        send(8'h01, 8'h02, 1'b1);
        @(negedge sysclk);
        send(8'h03, 8'h04, 1'b1);
        @(negedge sysclk);
        n_chk++; if (req_ready !== 1'b0) $display("FAIL bp_ready: got %b expected 0", req_ready); else n_pass++;
        repeat (5) @(negedge sysclk);
        n_chk++; if (req_ready !== 1'b0) $display("FAIL bp_hold: got %b expected 0", req_ready); else n_pass++;
        send(8'h05, 8'h06, 1'b0);
        @(negedge sysclk);
        wait_idle();
        n_chk++; if (fd_cnt - fd0 !== 3) $display("FAIL fd_b2b: got %0d expected 3", fd_cnt - fd0); else n_pass++;
    endtask

    task automatic test_stall();
        uart_mode = 1;
        repeat (2) @(negedge sysclk);
        send(8'h5A, 8'hC3, 1'b0);
        repeat (10) @(negedge sysclk);
        n_chk++; if (tx_en !== 1'b0) $display("FAIL stall_en: got %b expected 0", tx_en); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL stall_busy: got %b expected 1", busy); else n_pass++;
        @(posedge sysclk);
        #2;
        uart_mode = 0;
        @(negedge sysclk);
        n_chk++; if (tx_en !== 1'b0) $display("FAIL rel_pre: got %b expected 0", tx_en); else n_pass++;
        @(negedge sysclk);
        n_chk++; if (tx_en !== 1'b1) $display("FAIL rel_en: got %b expected 1", tx_en); else n_pass++;
        wait_idle();
    endtask

    task automatic test_timeout();
        int cnt;
        int fd0;
        fd0 = fd_cnt;
        uart_mode = 2;
        @(negedge sysclk);
        n_chk++; if (timeout_err !== 1'b0) $display("FAIL to_pre: got %b expected 0", timeout_err); else n_pass++;
        send(8'hC3, 8'h5A, 1'b0);
        for (int g = 0; g < 2; g++) begin
            wait_en(1'b1);
            wait_en(1'b0);
            cnt = 0;
            while (tx_en === 1'b0 && cnt < 100) begin
                cnt++;
                @(negedge sysclk);
            end
            n_chk++; if (cnt !== 18) $display("FAIL to_gap%0d: got %0d expected 18", g, cnt); else n_pass++;
        end
        wait_fd();
        @(negedge sysclk);
        n_chk++; if (timeout_err !== 1'b1) $display("FAIL to_err: got %b expected 1", timeout_err); else n_pass++;
        wait_idle();
        n_chk++; if (fd_cnt - fd0 !== 1) $display("FAIL fd_to: got %0d expected 1", fd_cnt - fd0); else n_pass++;
        uart_mode = 0;
    endtask

    task automatic test_reset_mid();
        int fd0;
        send(8'h77, 8'h88, 1'b0);
        wait_en(1'b1);
        wait_en(1'b0);
        wait_en(1'b1);
        @(negedge sysclk);
        reset = 1'b1;
        #1;
        n_chk++; if (tx_en !== 1'b0) $display("FAIL mid_en: got %b expected 0", tx_en); else n_pass++;
        n_chk++; if (req_ready !== 1'b1) $display("FAIL mid_ready: got %b expected 1", req_ready); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b expected 0", busy); else n_pass++;
        n_chk++; if (timeout_err !== 1'b0) $display("FAIL mid_to: got %b expected 0", timeout_err); else n_pass++;
        exp_q.delete();
        @(negedge sysclk);
        @(negedge sysclk);
        reset = 1'b0;
        @(negedge sysclk);
        fd0 = fd_cnt;
        send(8'hAA, 8'h55, 1'b0);
        @(negedge sysclk);
        wait_idle();
        n_chk++; if (fd_cnt - fd0 !== 1) $display("FAIL fd_after_rst: got %0d expected 1", fd_cnt - fd0); else n_pass++;
    endtask

`ifdef FRAME_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] got[4];
        send(8'h12, 8'h34, 1'b0);
        for (int k = 0; k < 4; k++) begin
            wait_en(1'b1);
            got[k] = tx_data;
            wait_en(1'b0);
        end
        n_chk++; if (got[3] !== 8'h2C) $display("FAIL cksum: got %02h expected 2c", got[3]); else n_pass++;
        wait_idle();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_timeout();
        test_reset_mid();
`ifdef FRAME_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
